// File: rtl/tlb_op_sequencer_pkg.sv
// tlb_params: shared types for the TLB instruction sequencer.
// Indices carried in the search result are sized for the largest supported
// TLB (64 entries); the sequencer keeps only the low IW bits.
package tlb_params;

    localparam int TLB_IDX_W = 6;

    typedef enum logic [1:0] {
        PROBE         = 2'd0,
        READ          = 2'd1,
        WRITE_INDEXED = 2'd2,
        WRITE_RANDOM  = 2'd3
    } tlb_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic [19:0] pfn;
        logic [2:0]  c;
        logic        d;
        logic        v;
    } tlb_entrylo_t;

    // EntryHi (vpn2, asid), global bit, EntryLo0, EntryLo1
    typedef struct packed {
        logic [18:0]  vpn2;
        logic [7:0]   asid;
        logic         g;
        tlb_entrylo_t lo0;
        tlb_entrylo_t lo1;
    } tlb_request_t;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        is_odd_page;
    } search_request_t;

    typedef struct packed {
        logic                 found;
        logic [TLB_IDX_W-1:0] index;
    } search_result_t;

endpackage

// File: rtl/tlb_random_counter.sv
// tlb_random_counter: free-running Random register. Counts down every cycle
// and reloads TLB_NUM-1 once it reaches (or sits below) the wired boundary,
// so the value always stays inside [wired, TLB_NUM-1].
module tlb_random_counter #(
    parameter int TLB_NUM = 16
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [$clog2(TLB_NUM)-1:0] wired,
    output logic [$clog2(TLB_NUM)-1:0] random
);

    localparam int IW = $clog2(TLB_NUM);
    localparam logic [IW-1:0] TOP_IDX = IW'(TLB_NUM - 1);

    logic [IW-1:0] r_random;

    // Down-count with reload at the wired boundary.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_random <= TOP_IDX;
        end else if (r_random <= wired) begin
            r_random <= TOP_IDX;
        end else begin
            r_random <= r_random - IW'(1);
        end
    end

    assign random = r_random;

endmodule

// File: rtl/tlb_op_sequencer.sv
// tlb_op_sequencer: executes one TLB instruction (probe, read, indexed or
// random write) per request against an external TLB with separate search,
// read and write ports. Each op takes exactly three cycles.
// Build option: TLB_RANDOM_WRITE_EN enables the Random counter; without it
// random reads 0 and WRITE_RANDOM writes at op_index like WRITE_INDEXED.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | ready for a request; op fields latched on acceptance
// ST_EXEC | TLB ports driven from latched op; results captured at end
// ST_DONE | one-cycle done pulse
module tlb_op_sequencer
    import tlb_params::*;
#(
    parameter int TLB_NUM = 16
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       op_valid,
    output logic                       op_ready,
    input  tlb_op_t                    op_code,
    input  tlb_request_t               op_entry,
    input  logic [$clog2(TLB_NUM)-1:0] op_index,
    input  logic [$clog2(TLB_NUM)-1:0] wired,
    output logic                       done,
    output logic                       probe_found,
    output logic [$clog2(TLB_NUM)-1:0] probe_index,
    output tlb_request_t               read_entry,
    output logic [$clog2(TLB_NUM)-1:0] random,
    output search_request_t            tlb_search_req,
    input  search_result_t             tlb_search_res,
    output logic                       tlb_we,
    output logic [$clog2(TLB_NUM)-1:0] tlb_w_index,
    output tlb_request_t               tlb_w_data,
    output logic [$clog2(TLB_NUM)-1:0] tlb_r_index,
    input  tlb_request_t               tlb_r_data
);

    localparam int IW = $clog2(TLB_NUM);

    seq_state_t    r_state;
    seq_state_t    w_next_state;
    tlb_op_t       r_op;
    tlb_request_t  r_entry;
    logic [IW-1:0] r_index;
    logic          r_probe_found;
    logic [IW-1:0] r_probe_index;
    tlb_request_t  r_read_entry;
    logic          w_accept;
    logic [IW-1:0] w_random;

`ifdef TLB_RANDOM_WRITE_EN
    tlb_random_counter #(
        .TLB_NUM (TLB_NUM)
    ) u_random (
        .clock   (clock),
        .reset_n (reset_n),
        .wired   (wired),
        .random  (w_random)
    );
`else
    logic w_unused_wired;
    assign w_unused_wired = ^wired;
    assign w_random       = '0;
`endif

    assign random   = w_random;
    assign w_accept = op_valid && (r_state == ST_IDLE);

    // State register; reset aborts any op in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state, handshake and TLB port drive from the latched op.
    always_comb begin
        w_next_state   = r_state;
        op_ready       = 1'b0;
        done           = 1'b0;
        tlb_we         = 1'b0;
        tlb_w_index    = '0;
        tlb_w_data     = '0;
        tlb_r_index    = '0;
        tlb_search_req = '0;
        case (r_state)
            ST_IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    w_next_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_next_state = ST_DONE;
                case (r_op)
                    PROBE: begin
                        tlb_search_req.vpn2        = r_entry.vpn2;
                        tlb_search_req.asid        = r_entry.asid;
                        tlb_search_req.is_odd_page = 1'b0;
                    end
                    READ: begin
                        tlb_r_index = r_index;
                    end
                    WRITE_INDEXED, WRITE_RANDOM: begin
                        tlb_we      = 1'b1;
                        tlb_w_index = r_index;
                        tlb_w_data  = r_entry;
                    end
                    default: ;
                endcase
            end
            ST_DONE: begin
                done         = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Latch the request; WRITE_RANDOM freezes the Random value at acceptance.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_op    <= PROBE;
            r_entry <= '0;
            r_index <= '0;
        end else if (w_accept) begin
            r_op    <= op_code;
            r_entry <= op_entry;
`ifdef TLB_RANDOM_WRITE_EN
            r_index <= (op_code == WRITE_RANDOM) ? w_random : op_index;
`else
            r_index <= op_index;
`endif
        end
    end

    // Capture probe/read results at the end of EXEC; writes leave them alone.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_probe_found <= 1'b0;
            r_probe_index <= '0;
            r_read_entry  <= '0;
        end else if (r_state == ST_EXEC) begin
            if (r_op == PROBE) begin
                r_probe_found <= tlb_search_res.found;
                r_probe_index <= IW'(tlb_search_res.index);
            end else if (r_op == READ) begin
                r_read_entry <= tlb_r_data;
            end
        end
    end

    assign probe_found = r_probe_found;
    assign probe_index = r_probe_index;
    assign read_entry  = r_read_entry;

endmodule

// File: tb/tb_tlb_op_sequencer.sv
// Bench for tlb_op_sequencer with a behavioural TLB on the search/read/write
// ports and a scoreboard of expected probe/read results popped on done.
`timescale 1ns/1ps
module tb_tlb_op_sequencer;
    import tlb_params::*;

    localparam int TLB_NUM = 16;
    localparam int IW      = $clog2(TLB_NUM);

    logic            clock = 1'b0;
    logic            reset_n;
    logic            op_valid;
    logic            op_ready;
    tlb_op_t         op_code;
    tlb_request_t    op_entry;
    logic [IW-1:0]   op_index;
    logic [IW-1:0]   wired;
    logic            done;
    logic            probe_found;
    logic [IW-1:0]   probe_index;
    tlb_request_t    read_entry;
    logic [IW-1:0]   random;
    search_request_t tlb_search_req;
    search_result_t  tlb_search_res;
    logic            tlb_we;
    logic [IW-1:0]   tlb_w_index;
    tlb_request_t    tlb_w_data;
    logic [IW-1:0]   tlb_r_index;
    tlb_request_t    tlb_r_data;

    always #5 clock = ~clock;

    tlb_op_sequencer #(.TLB_NUM(TLB_NUM)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .op_valid       (op_valid),
        .op_ready       (op_ready),
        .op_code        (op_code),
        .op_entry       (op_entry),
        .op_index       (op_index),
        .wired          (wired),
        .done           (done),
        .probe_found    (probe_found),
        .probe_index    (probe_index),
        .read_entry     (read_entry),
        .random         (random),
        .tlb_search_req (tlb_search_req),
        .tlb_search_res (tlb_search_res),
        .tlb_we         (tlb_we),
        .tlb_w_index    (tlb_w_index),
        .tlb_w_data     (tlb_w_data),
        .tlb_r_index    (tlb_r_index),
        .tlb_r_data     (tlb_r_data)
    );

    // Behavioural TLB
    tlb_request_t mem [TLB_NUM] = '{default: '0};
    logic         vld [TLB_NUM] = '{default: 1'b0};
    int           wr_count = 0;

    always @(posedge clock) begin
        if (tlb_we) begin
            mem[tlb_w_index] = tlb_w_data;
            vld[tlb_w_index] = 1'b1;
            wr_count         = wr_count + 1;
        end
    end

    always_comb begin
        tlb_search_res = '0;
        for (int i = 0; i < TLB_NUM; i++) begin
            if (!tlb_search_res.found && vld[i] && mem[i].vpn2 == tlb_search_req.vpn2 &&
                (mem[i].g || mem[i].asid == tlb_search_req.asid)) begin
                tlb_search_res.found = 1'b1;
                tlb_search_res.index = TLB_IDX_W'(i);
            end
        end
    end

    always_comb tlb_r_data = mem[tlb_r_index];

    function automatic search_result_t lookup(input logic [18:0] vpn2, input logic [7:0] asid);
        search_result_t r;
        r = '0;
        for (int i = 0; i < TLB_NUM; i++) begin
            if (!r.found && vld[i] && mem[i].vpn2 == vpn2 && (mem[i].g || mem[i].asid == asid)) begin
                r.found = 1'b1;
                r.index = TLB_IDX_W'(i);
            end
        end
        return r;
    endfunction

    // Checking
    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Scoreboard
    typedef struct {
        logic          found;
        logic [IW-1:0] pidx;
        tlb_request_t  rentry;
    } exp_t;

    exp_t sb_q[$];
    exp_t exp_state;
    exp_t mon_e;

    always @(negedge clock) begin
        if (reset_n && done) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check("sb_probe_found", probe_found, mon_e.found);
                check("sb_probe_index", probe_index, mon_e.pidx);
                check("sb_read_entry", read_entry, mon_e.rentry);
            end
        end
    end

    task automatic clear_expect();
        exp_state.found  = 1'b0;
        exp_state.pidx   = '0;
        exp_state.rentry = '0;
    endtask

    task automatic issue_op(input tlb_op_t code, input tlb_request_t ent,
                            input logic [IW-1:0] idx, input logic [IW-1:0] exp_widx);
        search_result_t  sr;
        search_request_t sq;
        logic            is_wr;
        int              n;
        n = 0;
        while (!op_ready && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        if (!op_ready) begin
            check("ready_timeout", 0, 1);
            return;
        end
        is_wr    = (code == WRITE_INDEXED) || (code == WRITE_RANDOM);
        op_valid = 1'b1;
        op_code  = code;
        op_entry = ent;
        op_index = idx;
        if (code == PROBE) begin
            sr = lookup(ent.vpn2, ent.asid);
            exp_state.found = sr.found;
            exp_state.pidx  = IW'(sr.index);
        end else if (code == READ) begin
            exp_state.rentry = mem[idx];
        end
        sb_q.push_back(exp_state);
        @(posedge clock); #1;
        op_valid = 1'b0;
        check("exec_ready", op_ready, 0);
        check("exec_done", done, 0);
        check("exec_we", tlb_we, is_wr);
        if (is_wr) begin
            check("exec_w_index", tlb_w_index, exp_widx);
            check("exec_w_data", tlb_w_data, ent);
        end
        if (code == PROBE) begin
            sq.vpn2 = ent.vpn2;
            sq.asid = ent.asid;
            sq.is_odd_page = 1'b0;
            check("exec_search", tlb_search_req, sq);
        end
        if (code == READ) check("exec_r_index", tlb_r_index, idx);
        @(posedge clock); #1;
        check("done_pulse", done, 1);
        check("done_we", tlb_we, 0);
        @(posedge clock); #1;
        check("done_low", done, 0);
        check("idle_ready", op_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tlb_request_t  e5, e9, e15, er, ea, pr;
        logic [IW-1:0] rnd_idx;
        int            wc;

        reset_n  = 1'b0;
        op_valid = 1'b0;
        op_code  = PROBE;
        op_entry = '0;
        op_index = '0;
        wired    = '0;
        clear_expect();

        e5 = '0; e5.vpn2 = 19'h12345; e5.asid = 8'h3A;
        e5.lo0.pfn = 20'h0ABCD; e5.lo0.c = 3'd3; e5.lo0.d = 1'b1; e5.lo0.v = 1'b1;
        e5.lo1.pfn = 20'h0ABCE; e5.lo1.c = 3'd2; e5.lo1.v = 1'b1;
        e9 = '0; e9.vpn2 = 19'h00777; e9.asid = 8'h11; e9.g = 1'b1;
        e9.lo0.pfn = 20'h55555; e9.lo1.pfn = 20'hAAAAA;
        e15 = '0; e15.vpn2 = 19'h7FFFF; e15.asid = 8'hFF; e15.lo0.pfn = 20'hFFFFF;
        er = '0; er.vpn2 = 19'h0BEEF; er.asid = 8'h42; er.lo1.pfn = 20'h12121;
        ea = '0; ea.vpn2 = 19'h0DEAD; ea.asid = 8'h07;

        repeat (2) @(posedge clock);
        #1;
        check("rst_ready", op_ready, 1);
        check("rst_done", done, 0);
        check("rst_we", tlb_we, 0);
        check("rst_probe_found", probe_found, 0);
        check("rst_probe_index", probe_index, 0);
        check("rst_read_entry", read_entry, 0);
`ifdef TLB_RANDOM_WRITE_EN
        check("rst_random", random, 15);
`else
        check("rst_random", random, 0);
`endif

        reset_n = 1'b1;
`ifdef TLB_RANDOM_WRITE_EN
        check("rand_w0", random, 15);
        for (int i = 1; i <= 16; i++) begin
            @(posedge clock); #1;
            check("rand_w0", random, (i == 16) ? 15 : 15 - i);
        end
`else
        for (int i = 1; i <= 4; i++) begin
            @(posedge clock); #1;
            check("rand_tied0", random, 0);
        end
`endif

        issue_op(WRITE_INDEXED, e5, 4'd5, 4'd5);
        check("tlb_mem5", mem[5], e5);
        pr = '0; pr.vpn2 = 19'h12345; pr.asid = 8'h3A;
        issue_op(PROBE, pr, 4'd0, 4'd0);
        check("probe_hit_found", probe_found, 1);
        check("probe_hit_index", probe_index, 5);
        pr.vpn2 = 19'h00001;
        issue_op(PROBE, pr, 4'd0, 4'd0);
        check("probe_miss", probe_found, 0);

        issue_op(WRITE_INDEXED, e9, 4'd9, 4'd9);
        pr = '0; pr.vpn2 = 19'h00777; pr.asid = 8'h55;
        issue_op(PROBE, pr, 4'd0, 4'd0);
        check("probe_global_index", probe_index, 9);
        issue_op(READ, '0, 4'd5, 4'd0);
        check("read5", read_entry, e5);
        issue_op(WRITE_INDEXED, e15, 4'd15, 4'd15);
        check("write_keeps_read", read_entry, e5);
        check("write_keeps_probe", probe_index, 9);
        issue_op(READ, '0, 4'd15, 4'd0);
        check("read15", read_entry, e15);

        // op_valid held high: one acceptance every three cycles
        exp_state.rentry = mem[5];
        repeat (3) sb_q.push_back(exp_state);
        op_valid = 1'b1;
        op_code  = READ;
        op_index = 4'd5;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clock); #1;
            check("b2b_done", done, (k % 3) == 2);
            check("b2b_ready", op_ready, (k % 3) == 0);
        end
        op_valid = 1'b0;
        check("b2b_read", read_entry, e5);

        // wired = 12 and WRITE_RANDOM
        reset_n = 1'b0;
        wired   = 4'd12;
        clear_expect();
        @(posedge clock); #1;
        check("rst2_read_entry", read_entry, 0);
        check("rst2_probe_index", probe_index, 0);
        reset_n = 1'b1;
`ifdef TLB_RANDOM_WRITE_EN
        check("rand_w12", random, 15);
        begin
            int seq [5] = '{14, 13, 12, 15, 14};
            for (int i = 0; i < 5; i++) begin
                @(posedge clock); #1;
                check("rand_w12", random, seq[i]);
            end
        end
        rnd_idx = 4'd14;
`else
        repeat (5) @(posedge clock);
        #1;
        rnd_idx = 4'd3;
`endif
        issue_op(WRITE_RANDOM, er, 4'd3, rnd_idx);
        issue_op(READ, '0, rnd_idx, 4'd0);
        check("read_random_slot", read_entry, er);

        // reset during EXEC of a write
        op_valid = 1'b1;
        op_code  = WRITE_INDEXED;
        op_entry = ea;
        op_index = 4'd7;
        @(posedge clock); #1;
        op_valid = 1'b0;
        check("abort_exec_we", tlb_we, 1);
        wc = wr_count;
        reset_n = 1'b0;
        clear_expect();
        #1;
        check("abort_we_low", tlb_we, 0);
        check("abort_ready", op_ready, 1);
        check("abort_done", done, 0);
        @(posedge clock); #1;
        check("abort_no_write", wr_count, wc);
        check("abort_slot7", vld[7], 0);
        reset_n = 1'b1;
        repeat (3) begin
            @(posedge clock); #1;
            check("abort_idle_done", done, 0);
            check("abort_idle_ready", op_ready, 1);
        end
        check("abort_read_entry", read_entry, 0);

        check("sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
